// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master
//  Purpose  : Mode-0, MSB-first, 8-bit SPI master with programmable sclk
//             divider and cs-held back-to-back bursts.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold_cs,
    input  logic [7:0] data_send_master,
    output logic       busy,
    output logic [7:0] data_receive_master,
    output logic       data_receive_master_enable,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso
);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("spi_master: CLK_DIV must lie in 2..255");
        end
    endgenerate

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] c_LAST_RISE_EDGE = 5'd15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_XFER      = 3'd2,
        ST_HOLD      = 3'd3,
        ST_WAIT_NEXT = 3'd4,
        ST_GAP       = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] div_cnt_q, div_cnt_d;
    logic [4:0] edge_cnt_q, edge_cnt_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_en_q, rx_en_d;
    logic       cs_q, cs_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       w_tick;

    assign w_tick = (div_cnt_q == c_DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        edge_cnt_d = edge_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_en_d    = 1'b0;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;

        case (state_q)
            ST_IDLE: begin
                div_cnt_d = 8'd0;
                if (start) begin
                    tx_sr_d = data_send_master;
                    mosi_d  = data_send_master[7];
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (w_tick) begin
                    div_cnt_d  = 8'd0;
                    sclk_d     = 1'b1;
                    rx_sr_d    = {rx_sr_q[6:0], miso};
                    edge_cnt_d = 5'd1;
                    state_d    = ST_XFER;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            ST_XFER: begin
                if (w_tick) begin
                    div_cnt_d  = 8'd0;
                    sclk_d     = ~sclk_q;
                    edge_cnt_d = edge_cnt_q + 5'd1;
                    if (!sclk_q) begin
                        rx_sr_d = {rx_sr_q[6:0], miso};
                    end else if (edge_cnt_q == c_LAST_RISE_EDGE) begin
                        // 16th edge: mosi keeps bit 0 through HOLD
                        edge_cnt_d = 5'd0;
                        state_d    = ST_HOLD;
                    end else begin
                        mosi_d  = tx_sr_q[6];
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            ST_HOLD: begin
                // The cycle carrying the enable pulse is where hold_cs decides
                // the exit, so cs rises one clk after the received byte appears.
                if (rx_en_q) begin
                    if (hold_cs) begin
                        busy_d  = 1'b0;
                        state_d = ST_WAIT_NEXT;
                    end else begin
                        cs_d    = 1'b1;
                        state_d = ST_GAP;
                    end
                end else if (w_tick) begin
                    div_cnt_d = 8'd0;
                    rx_data_d = rx_sr_q;
                    rx_en_d   = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            ST_WAIT_NEXT: begin
                div_cnt_d = 8'd0;
                if (start) begin
                    tx_sr_d = data_send_master;
                    mosi_d  = data_send_master[7];
                    busy_d  = 1'b1;
                    state_d = ST_SETUP;
                end else if (!hold_cs) begin
                    cs_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_GAP;
                end
            end

            ST_GAP: begin
                if (w_tick) begin
                    div_cnt_d = 8'd0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= 8'd0;
            edge_cnt_q <= 5'd0;
            tx_sr_q    <= 8'd0;
            rx_sr_q    <= 8'd0;
            rx_data_q  <= 8'd0;
            rx_en_q    <= 1'b0;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_en_q    <= rx_en_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
        end
    end

    assign busy                       = busy_q;
    assign data_receive_master        = rx_data_q;
    assign data_receive_master_enable = rx_en_q;
    assign cs                         = cs_q;
    assign sclk                       = sclk_q;
    assign mosi                       = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master
//  Purpose  : Scoreboard bench for spi_master at CLK_DIV = 2, 4 and 7.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_a = 3'b000;
    logic       hold_cs = 1'b0;
    logic [7:0] dsm     = 8'h00;
    logic [2:0] busy_a, en_a, cs_a, sclk_a, mosi_a, miso_a;
    logic [7:0] drm_a [3];
    logic       loopback = 1'b0;
    logic       miso_s   = 1'b0;

    int divs [3] = '{2, 4, 7};
    logic [1:0] sel     = 2'd1;
    int         div_sel = 4;
    int         cyc     = 0;

    logic w_cs, w_sclk, w_mosi, w_busy, w_en;
    logic [7:0] w_drm;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign miso_a = loopback ? mosi_a : {3{miso_s}};
    assign w_cs   = cs_a[sel];
    assign w_sclk = sclk_a[sel];
    assign w_mosi = mosi_a[sel];
    assign w_busy = busy_a[sel];
    assign w_en   = en_a[sel];
    assign w_drm  = drm_a[sel];

    spi_master #(.CLK_DIV(2)) u_dut_d2 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .hold_cs(hold_cs),
        .data_send_master(dsm), .busy(busy_a[0]), .data_receive_master(drm_a[0]),
        .data_receive_master_enable(en_a[0]), .cs(cs_a[0]), .sclk(sclk_a[0]),
        .mosi(mosi_a[0]), .miso(miso_a[0])
    );
    spi_master #(.CLK_DIV(4)) u_dut_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .hold_cs(hold_cs),
        .data_send_master(dsm), .busy(busy_a[1]), .data_receive_master(drm_a[1]),
        .data_receive_master_enable(en_a[1]), .cs(cs_a[1]), .sclk(sclk_a[1]),
        .mosi(mosi_a[1]), .miso(miso_a[1])
    );
    spi_master #(.CLK_DIV(7)) u_dut_d7 (
        .clk(clk), .rst_n(rst_n), .start(start_a[2]), .hold_cs(hold_cs),
        .data_send_master(dsm), .busy(busy_a[2]), .data_receive_master(drm_a[2]),
        .data_receive_master_enable(en_a[2]), .cs(cs_a[2]), .sclk(sclk_a[2]),
        .mosi(mosi_a[2]), .miso(miso_a[2])
    );

    int   nvec  = 0;
    int   nfail = 0;
    exp_t rx_q [$];
    bit   mosi_exp [$];
    bit   mosi_chk = 1'b1;

    task automatic check(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Mode-0 slave: presents bit 7 at cs fall and the next bit after each sclk fall
    logic [7:0] slave_pat = 8'h00;
    logic [2:0] s_idx     = 3'd0;
    logic       s_prev_cs = 1'b1;
    logic       s_prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (s_prev_cs && !w_cs)
            s_idx = 3'd0;
        else if (s_prev_sclk && !w_sclk)
            s_idx = s_idx + 3'd1;
        miso_s      = slave_pat[~s_idx];
        s_prev_cs   = w_cs;
        s_prev_sclk = w_sclk;
    end

    logic prev_sclk = 1'b0;
    int   last_tr   = 0;
    int   tr_cnt    = 0;
    int   rises     = 0;
    int   en_count  = 0;
    bit   cs_watch  = 1'b0;
    int   cs_hi_seen = 0;
    exp_t e_m;
    always @(negedge clk) begin
        if (w_cs) tr_cnt = 0;
        if (rst_n) begin
            if (cs_watch && w_cs) cs_hi_seen++;
            if (w_en) begin
                en_count++;
                if (rx_q.size() == 0) begin
                    check("unexpected_enable", 1, 0);
                end else begin
                    e_m = rx_q.pop_front();
                    check("rx_data", w_drm, e_m.data);
                    check("enable_cycle", cyc, e_m.cyc);
                end
            end
            if (w_sclk != prev_sclk) begin
                if (w_sclk) begin
                    rises++;
                    check("cs_low_at_rise", w_cs, 0);
                    if (mosi_chk) begin
                        if (mosi_exp.size() == 0) check("unexpected_rise", 1, 0);
                        else check("mosi_bit", w_mosi, mosi_exp.pop_front());
                    end
                end
                if (tr_cnt % 16 != 0) check("sclk_half_period", cyc - last_tr, div_sel);
                tr_cnt++;
                last_tr = cyc;
            end
        end
        prev_sclk = w_sclk;
    end

    task automatic goto_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_cyc(input int n);
        if (n < cyc) begin
            check("schedule_overrun", cyc, n);
        end else begin
            while (!(cyc == n && clk == 1'b0)) @(negedge clk);
        end
    endtask

    task automatic select(input int idx);
        sel     = 2'(idx);
        div_sel = divs[idx];
    endtask

    // Raises start in the current cycle (t0) and pushes the expected response
    task automatic issue(input int idx, input logic [7:0] tx, input logic [7:0] rx_exp,
                         input bit expect_rx, output int t0);
        exp_t e;
        t0 = cyc;
        start_a[idx] = 1'b1;
        dsm = tx;
        if (expect_rx) begin
            e.data = rx_exp;
            e.cyc  = t0 + 1 + 17 * divs[idx];
            rx_q.push_back(e);
            for (int i = 7; i >= 0; i--) mosi_exp.push_back(tx[i]);
        end
        @(posedge clk);
        #1;
        start_a[idx] = 1'b0;
        dsm = 8'h00;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0, t1, r0, e0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs", w_cs, 1);
        check("rst_sclk", w_sclk, 0);
        check("rst_mosi", w_mosi, 0);
        check("rst_busy", w_busy, 0);
        check("rst_drm", w_drm, 8'h00);
        check("rst_en", w_en, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single byte A5 out, 3C back
        select(1);
        slave_pat = 8'h3C;
        hold_cs = 1'b0;
        r0 = rises;
        goto_cyc(cyc + 1);
        issue(1, 8'hA5, 8'h3C, 1'b1, t0);
        at_cyc(t0 + 1);  check("single_cs_low", w_cs, 0);
        check("single_busy", w_busy, 1);
        check("single_mosi7", w_mosi, 1);
        at_cyc(t0 + 4);  check("single_sclk_pre", w_sclk, 0);
        at_cyc(t0 + 5);  check("single_first_rise", w_sclk, 1);
        at_cyc(t0 + 61); check("single_last_rise", w_sclk, 1);
        at_cyc(t0 + 65); check("single_last_fall", w_sclk, 0);
        check("single_mosi_bit0_kept", w_mosi, 1);
        at_cyc(t0 + 69); check("single_cs_at_en", w_cs, 0);
        at_cyc(t0 + 70); check("single_cs_high", w_cs, 1);
        check("single_drm", w_drm, 8'h3C);
        at_cyc(t0 + 73); check("single_busy_gap", w_busy, 1);
        at_cyc(t0 + 74); check("single_busy_low", w_busy, 0);
        check("single_rises", rises - r0, 8);
        check("single_pending", rx_q.size(), 0);

        // Reset mid-transfer at edge 7
        mosi_chk = 1'b0;
        slave_pat = 8'hE7;
        e0 = en_count;
        goto_cyc(cyc + 1);
        issue(1, 8'h5A, 8'h00, 1'b0, t0);
        at_cyc(t0 + 29); check("rstx_sclk_edge7", w_sclk, 1);
        goto_cyc(t0 + 30);
        rst_n = 1'b0;
        #1;
        check("rstx_cs_async", w_cs, 1);
        check("rstx_sclk_async", w_sclk, 0);
        goto_cyc(t0 + 32);
        rst_n = 1'b1;
        at_cyc(t0 + 33);
        check("rstx_busy", w_busy, 0);
        check("rstx_drm", w_drm, 8'h00);
        at_cyc(t0 + 120);
        check("rstx_no_enable", en_count - e0, 0);
        mosi_chk = 1'b1;

        // Burst 81 then 7E with cs held low
        hold_cs = 1'b1;
        slave_pat = 8'h96;
        r0 = rises;
        goto_cyc(cyc + 1);
        issue(1, 8'h81, 8'h96, 1'b1, t0);
        cs_hi_seen = 0;
        cs_watch = 1'b1;
        goto_cyc(t0 + 70);
        check("burst_wait_busy", w_busy, 0);
        slave_pat = 8'h69;
        issue(1, 8'h7E, 8'h69, 1'b1, t1);
        hold_cs = 1'b0;
        at_cyc(t1 + 69);
        cs_watch = 1'b0;
        check("burst_cs_held", cs_hi_seen, 0);
        at_cyc(t1 + 70); check("burst_cs_high", w_cs, 1);
        at_cyc(t1 + 74); check("burst_busy_low", w_busy, 0);
        check("burst_rises", rises - r0, 16);
        check("burst_pending", rx_q.size(), 0);

        // Start pulses while busy are ignored
        slave_pat = 8'h5A;
        r0 = rises;
        e0 = en_count;
        goto_cyc(cyc + 1);
        issue(1, 8'h00, 8'h5A, 1'b1, t0);
        goto_cyc(t0 + 10); start_a[1] = 1'b1; dsm = 8'hFF;
        goto_cyc(t0 + 11); start_a[1] = 1'b0; dsm = 8'h00;
        goto_cyc(t0 + 40); start_a[1] = 1'b1; dsm = 8'hFF;
        goto_cyc(t0 + 41); start_a[1] = 1'b0; dsm = 8'h00;
        at_cyc(t0 + 100);
        check("ign_one_enable", en_count - e0, 1);
        check("ign_rises", rises - r0, 8);
        check("ign_cs_idle", w_cs, 1);
        check("ign_busy_idle", w_busy, 0);

        // Divider sweep with loopback
        loopback = 1'b1;
        select(0);
        r0 = rises;
        goto_cyc(cyc + 1);
        issue(0, 8'hC3, 8'hC3, 1'b1, t0);
        at_cyc(t0 + 35); check("d2_drm", w_drm, 8'hC3);
        at_cyc(t0 + 38); check("d2_busy_low", w_busy, 0);
        check("d2_rises", rises - r0, 8);
        select(2);
        r0 = rises;
        goto_cyc(cyc + 1);
        issue(2, 8'hC3, 8'hC3, 1'b1, t0);
        at_cyc(t0 + 120); check("d7_drm", w_drm, 8'hC3);
        at_cyc(t0 + 128); check("d7_busy_low", w_busy, 0);
        check("d7_rises", rises - r0, 8);
        loopback = 1'b0;

        // Leave WAIT_NEXT by dropping hold_cs
        select(1);
        hold_cs = 1'b1;
        slave_pat = 8'hC6;
        goto_cyc(cyc + 1);
        issue(1, 8'h3C, 8'hC6, 1'b1, t0);
        at_cyc(t0 + 71);
        check("wn_busy", w_busy, 0);
        check("wn_cs", w_cs, 0);
        goto_cyc(t0 + 72);
        hold_cs = 1'b0;
        at_cyc(t0 + 72); check("wn_cs_still_low", w_cs, 0);
        at_cyc(t0 + 73); check("wn_cs_high", w_cs, 1);
        check("wn_gap_busy", w_busy, 1);
        at_cyc(t0 + 76); check("wn_gap_busy_end", w_busy, 1);
        at_cyc(t0 + 77); check("wn_idle_busy", w_busy, 0);
        check("final_pending_rx", rx_q.size(), 0);
        check("final_pending_mosi", mosi_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_master.md
Name: spi_master

Overview:
- Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI master.
- Drives cs, sclk and mosi; samples miso. It is the initiating end of the SPI link served by the team's spi slave block.
- Derives sclk from a single system clock through a programmable half-period divider.
- Supports single-byte transfers and back-to-back bursts with cs held low between bytes.

Parameters:
- CLK_DIV, 4, system clocks per sclk half-period; legal range 2..255; elaboration error outside that range.

Ports:
- clk  input  1  system clock, all state updates on its rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a byte transfer; sampled only in IDLE or WAIT_NEXT
- hold_cs  input  1  sampled at end of byte; 1 keeps cs low for a following byte
- data_send_master  input  8  byte to transmit; captured on the accepted start cycle
- busy  output  1  high from accepted start until return to IDLE, except in WAIT_NEXT
- data_receive_master  output  8  last received byte; held until next update
- data_receive_master_enable  output  1  one-clk pulse when data_receive_master updates
- cs  output  1  active-low chip select to slave
- sclk  output  1  serial clock, idles low
- mosi  output  1  serial data to slave
- miso  input  1  serial data from slave

Behaviour:
- Reset (async assert, sync release): cs=1, sclk=0, mosi=0, busy=0, data_receive_master=8'h00, data_receive_master_enable=0, state=IDLE, all counters 0.
- Reset mid-transfer: cs rises and sclk falls immediately; the partial byte is discarded and no enable pulse is produced.
- Outputs are registered. div_cnt counts 0..CLK_DIV-1, and a "tick" is div_cnt==CLK_DIV-1.
- IDLE: on start=1 (cycle 0) the block captures data_send_master into tx_sr. In cycle 1: cs=0, mosi=tx_sr[7], busy=1, go to SETUP.
- SETUP: lasts CLK_DIV clks. On tick, sclk goes 1 (rise 1) and the block enters XFER.
- XFER: edges 2..16 occur one per tick; edge_cnt tracks the edge number.
  - Each rise: rx_sr <= {rx_sr[6:0], miso}.
  - Each fall except the 16th: mosi shifts to the next lower tx bit.
  - After the 16th edge (a fall, sclk=0), go to HOLD. mosi keeps bit 0.
- HOLD: lasts CLK_DIV clks with cs low. On tick:
  - data_receive_master <= rx_sr and data_receive_master_enable=1 for one clk.
  - Next state is WAIT_NEXT if hold_cs=1, else GAP with cs=1.
- WAIT_NEXT: cs=0, sclk=0, busy=0.
  - start=1: capture new byte, mosi=bit7, busy=1, go to SETUP. No cs deassertion occurs.
  - hold_cs=0 with start=0: cs=1, go to GAP.
  - start=1 and hold_cs=0 in the same cycle: start wins.
- GAP: cs=1 for CLK_DIV clks, busy=1, then IDLE. This guarantees the slave sees a minimum cs-high time.
- Timing, CLK_DIV=4, start accepted at cycle 0:
  - cs low at cycle 1
  - sclk rises at 5, 13, 21, ..., 61
  - last fall at 65
  - data_receive_master_enable at 69
  - cs high at 70
  - busy low at 74
  - General form: enable at 1+17*CLK_DIV.
- sclk duty is exactly 50% with period 2*CLK_DIV clks. sclk never toggles while cs=1.
- start is ignored while busy=1. data_send_master is don't-care outside the capture cycle. miso is sampled only at rising sclk.
- miso is assumed synchronous to clk; no synchronizer is required.

Test Plan:
- Reset values: assert rst_n=0 mid-XFER (edge 7) -> same cycle cs=1, sclk=0; after release busy=0, data_receive_master=00, no enable pulse.
- Single byte: CLK_DIV=4, data_send_master=A5, slave model returns 3C on miso (mode 0) -> mosi bits 1,0,1,0,0,1,0,1 valid at each sclk rise; data_receive_master=3C with enable pulse at cycle 69; cs high at 70; busy low at 74; exactly 8 sclk rises.
- Burst: hold_cs=1, bytes 81 then 7E, second start in first WAIT_NEXT cycle -> cs stays low across both bytes; two enable pulses 1+17*CLK_DIV apart plus one cycle; 16 sclk rises; cs rises only after byte 2.
- Ignored start: pulse start=1 with data_send_master=FF at cycles 10 and 40 of a 00 transfer -> mosi stays all zero; only one enable pulse; no restart.
- Divider sweep: CLK_DIV=2 and CLK_DIV=7, loopback miso=mosi, tx C3 -> rx C3; sclk half-period exactly 2 and 7 clks; enable at cycles 35 and 120.
- WAIT_NEXT exit: hold_cs=1 for byte 1, then drop hold_cs with no start -> cs=1 next cycle, busy=1 for CLK_DIV clks, then IDLE with busy=0.
